// File: rtl/regctx_engine.sv
// Register-context save/restore engine for the CPU 16x16 register file (optional REGCTX_MASK_EN adds i_mask).
// Latency: 2 cycles per selected register plus 1 DONE cycle (31 cycles for a full save/restore with immediate acks).
// Backpressure: waits indefinitely on i_mem_ack with address/data held stable; starts ignored while busy.
module regctx_engine #(
   parameter int DW        = 16,
   parameter int AW        = 16,
   parameter int ADDR_STEP = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_save,
   input  logic          i_restore,
   input  logic [AW-1:0] i_base,
`ifdef REGCTX_MASK_EN
   input  logic [15:0]   i_mask,
`endif
   output logic          o_busy,
   output logic          o_done,
   output logic [AW-1:0] o_end_addr,
   output logic [3:0]    o_rf_ad,
   input  logic [DW-1:0] i_rf_q,
   output logic          o_rf_we,
   output logic [3:0]    o_rf_wr_ad,
   output logic [DW-1:0] o_rf_d,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SV_RD,
      ST_SV_WR,
      ST_RS_RD,
      ST_RS_WR,
      ST_DONE
   } state_t;

   localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

   // r0 is never part of a context, whatever the mask says
`ifdef REGCTX_MASK_EN
   logic [15:0] mask_in;
   assign mask_in = i_mask & 16'hFFFE;
`else
   logic [15:0] mask_in;
   assign mask_in = 16'hFFFE;
`endif

   // highest selected index <= lim; bit 4 of the result flags "found"
   function automatic logic [4:0] pick_le(input logic [15:0] m, input logic [3:0] lim);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (m[i] && (4'(i) <= lim)) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   // lowest selected index >= lim; bit 4 of the result flags "found"
   function automatic logic [4:0] pick_ge(input logic [15:0] m, input logic [3:0] lim);
      logic [4:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i] && (4'(i) >= lim)) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   state_t          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [15:0]     mask_q, mask_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [AW-1:0]   end_addr_q, end_addr_d;
   logic [3:0]      rf_ad_q, rf_ad_d;
   logic            rf_we_q, rf_we_d;
   logic [3:0]      rf_wr_ad_q, rf_wr_ad_d;
   logic [DW-1:0]   rf_d_q, rf_d_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [4:0]      sel;

   // next state, datapath and registered outputs derived from the next state
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      data_d   = data_q;
      mask_d   = mask_q;
      sel      = '0;

      case (state_q)
         ST_IDLE: begin
            if (i_save) begin
               mask_d  = mask_in;
               addr_d  = i_base;
               sel     = pick_le(mask_in, 4'd15);
               idx_d   = sel[3:0];
               state_d = sel[4] ? ST_SV_RD : ST_DONE;
            end else if (i_restore) begin
               mask_d  = mask_in;
               addr_d  = i_base;
               sel     = pick_ge(mask_in, 4'd1);
               idx_d   = sel[3:0];
               state_d = sel[4] ? ST_RS_RD : ST_DONE;
            end
         end
         ST_SV_RD: begin
            data_d  = i_rf_q;
            addr_d  = addr_q - STEP;
            state_d = ST_SV_WR;
         end
         ST_SV_WR: begin
            if (i_mem_ack) begin
               // idx_q >= 1 here since r0 is never selected
               sel     = pick_le(mask_q, idx_q - 4'd1);
               idx_d   = sel[4] ? sel[3:0] : idx_q;
               state_d = sel[4] ? ST_SV_RD : ST_DONE;
            end
         end
         ST_RS_RD: begin
            if (i_mem_ack) begin
               data_d  = i_mem_rdata;
               addr_d  = addr_q + STEP;
               state_d = ST_RS_WR;
            end
         end
         ST_RS_WR: begin
            if (idx_q != 4'd15) sel = pick_ge(mask_q, idx_q + 4'd1);
            idx_d   = sel[4] ? sel[3:0] : idx_q;
            state_d = sel[4] ? ST_RS_RD : ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      end_addr_d  = (state_d == ST_DONE) ? addr_d : end_addr_q;
      rf_ad_d     = (state_d == ST_SV_RD) ? idx_d : 4'd0;
      rf_we_d     = (state_d == ST_RS_WR);
      rf_wr_ad_d  = (state_d == ST_RS_WR) ? idx_d : 4'd0;
      rf_d_d      = (state_d == ST_RS_WR) ? data_d : '0;
      mem_req_d   = (state_d == ST_SV_WR) || (state_d == ST_RS_RD);
      mem_we_d    = (state_d == ST_SV_WR);
      mem_addr_d  = mem_req_d ? addr_d : '0;
      mem_wdata_d = (state_d == ST_SV_WR) ? data_d : '0;
   end

   // state and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         mask_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         end_addr_q  <= '0;
         rf_ad_q     <= '0;
         rf_we_q     <= 1'b0;
         rf_wr_ad_q  <= '0;
         rf_d_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         end_addr_q  <= end_addr_d;
         rf_ad_q     <= rf_ad_d;
         rf_we_q     <= rf_we_d;
         rf_wr_ad_q  <= rf_wr_ad_d;
         rf_d_q      <= rf_d_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_end_addr  = end_addr_q;
   assign o_rf_ad     = rf_ad_q;
   assign o_rf_we     = rf_we_q;
   assign o_rf_wr_ad  = rf_wr_ad_q;
   assign o_rf_d      = rf_d_q;
   assign o_mem_req   = mem_req_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;

endmodule
